// File: rtl/axi_rd_dma_burst.sv
// AXI4 read DMA master: splits a rd_len-beat transfer into 4 KB-safe bursts of at
// most MAX_BURST_LEN beats and streams every returned beat into a local memory port.
module axi_rd_dma_burst #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int MAX_BURST_LEN  = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,
  input  logic                      start_dma_r,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [LEN_WIDTH-1:0]      rd_len,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_base_waddr,
  output logic                      dma_r_busy,
  output logic                      dma_r_done,
  output logic                      dma_r_err,
  output logic                      wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [ID_WIDTH-1:0]       M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                M_AXI_ARLEN,
  output logic [2:0]                M_AXI_ARSIZE,
  output logic [1:0]                M_AXI_ARBURST,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]       M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RLAST,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  // Wide enough to compare rd_len, 4096 and MAX_BURST_LEN without truncation.
  localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH + 1 : 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [LEN_WIDTH-1:0]      beats_left;
  logic [MEM_ADDR_WIDTH-1:0] ptr;
  logic [8:0]                blen;
  logic [8:0]                beat_cnt;
  logic [CW-1:0]             to_4k;
  logic [CW-1:0]             blen_calc;
  logic                      last_beat;
  logic                      unused_ok;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARSIZE  = 3'(OFFS);
  assign M_AXI_ARBURST = 2'b01;

  assign last_beat = (beat_cnt == blen - 9'd1);
  assign unused_ok = ^{M_AXI_RID, araddr[OFFS-1:0], blen_calc[CW-1:9]};

  // NOTE: blen_calc is assigned a default before the conditional overrides, so
  // every path through this block writes it and no latch can be inferred.
  always_comb begin
    to_4k     = CW'((13'd4096 - {1'b0, addr[11:0]}) >> OFFS);
    blen_calc = CW'(MAX_BURST_LEN);
    if (CW'(beats_left) < blen_calc) blen_calc = CW'(beats_left);
    if (to_4k < blen_calc)           blen_calc = to_4k;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the values from before this edge, independent of statement order.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= S_IDLE;
      addr          <= '0;
      beats_left    <= '0;
      ptr           <= '0;
      blen          <= '0;
      beat_cnt      <= '0;
      dma_r_busy    <= 1'b0;
      dma_r_done    <= 1'b0;
      dma_r_err     <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      dma_r_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_dma_r) begin
            addr       <= {araddr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
            beats_left <= rd_len;
            ptr        <= mem_base_waddr;
            dma_r_err  <= 1'b0;
            if (rd_len == '0) begin
              state      <= S_DONE;
              dma_r_done <= 1'b1;
            end else begin
              state      <= S_CALC;
              dma_r_busy <= 1'b1;
            end
          end
        end
        S_CALC: begin
          blen          <= blen_calc[8:0];
          M_AXI_ARADDR  <= addr;
          M_AXI_ARLEN   <= 8'(blen_calc - CW'(1));
          M_AXI_ARVALID <= 1'b1;
          state         <= S_ADDR;
        end
        S_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            beat_cnt      <= '0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (M_AXI_RVALID) begin
            wr_en    <= 1'b1;
            wr_data  <= M_AXI_RDATA;
            wr_addr  <= ptr;
            ptr      <= ptr + MEM_ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt + 9'd1;
            // Protocol errors are flagged but the beat is still stored.
            if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != last_beat) dma_r_err <= 1'b1;
            // The burst is closed by our own beat count, not by RLAST.
            if (last_beat) begin
              M_AXI_RREADY <= 1'b0;
              addr         <= addr + (ADDR_WIDTH'(blen) << OFFS);
              beats_left   <= beats_left - LEN_WIDTH'(blen);
              if (beats_left == LEN_WIDTH'(blen)) begin
                state      <= S_DONE;
                dma_r_done <= 1'b1;
                dma_r_busy <= 1'b0;
              end else begin
                state <= S_CALC;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_dma_burst.sv
// Scoreboard bench for axi_rd_dma_burst: an AXI read slave model feeds beats while
// expected AR requests and local writes are queued at start and popped on DUT output.
module tb_axi_rd_dma_burst;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 1;
  localparam int MBL = 16;
  localparam int LW  = 16;
  localparam int MAW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_dma_r;
  logic [AW-1:0]  araddr;
  logic [LW-1:0]  rd_len;
  logic [MAW-1:0] mem_base_waddr;
  logic           dma_r_busy, dma_r_done, dma_r_err;
  logic           wr_en;
  logic [MAW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;
  logic [IW-1:0]  arid;
  logic [AW-1:0]  ar_addr;
  logic [7:0]     ar_len;
  logic [2:0]     ar_size;
  logic [1:0]     ar_burst;
  logic           ar_valid, ar_ready;
  logic [IW-1:0]  r_id;
  logic [DW-1:0]  r_data;
  logic [1:0]     r_resp;
  logic           r_last, r_valid, r_ready;

  always #5 clk = ~clk;

  axi_rd_dma_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MAX_BURST_LEN(MBL), .LEN_WIDTH(LW), .MEM_ADDR_WIDTH(MAW)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .start_dma_r(start_dma_r),
    .araddr(araddr),
    .rd_len(rd_len),
    .mem_base_waddr(mem_base_waddr),
    .dma_r_busy(dma_r_busy),
    .dma_r_done(dma_r_done),
    .dma_r_err(dma_r_err),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .M_AXI_ARID(arid),
    .M_AXI_ARADDR(ar_addr),
    .M_AXI_ARLEN(ar_len),
    .M_AXI_ARSIZE(ar_size),
    .M_AXI_ARBURST(ar_burst),
    .M_AXI_ARVALID(ar_valid),
    .M_AXI_ARREADY(ar_ready),
    .M_AXI_RID(r_id),
    .M_AXI_RDATA(r_data),
    .M_AXI_RRESP(r_resp),
    .M_AXI_RLAST(r_last),
    .M_AXI_RVALID(r_valid),
    .M_AXI_RREADY(r_ready)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  typedef struct packed {
    logic [MAW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_t;

  ar_t        exp_arq[$];
  wr_t        exp_wq[$];
  logic [7:0] burst_q[$];

  int checks = 0;
  int errors = 0;

  // Slave configuration and state
  int          cfg_ar_stall   = 0;
  int          cfg_gap_pct    = 0;
  int          cfg_err_beat   = -1;
  int          cfg_early_last = -1;
  logic [15:0] cfg_tag        = '0;
  int          slave_beat     = 0;
  int          beat_in_burst  = 0;
  int          ar_wait        = 0;
  bit          ar_hs, r_hs;
  logic [7:0]  ar_len_s;

  // Monitor state
  int            done_cnt    = 0;
  int            wr_cnt      = 0;
  int            arv_cycles  = 0;
  logic          exp_err     = 1'b0;
  logic          exp_last_wr = 1'b0;
  logic          prev_stall  = 1'b0;
  logic [AW-1:0] prev_addr   = '0;
  logic [7:0]    prev_len    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // AXI read slave: ARREADY after cfg_ar_stall cycles, R beats with random gaps.
  initial begin
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_data   = '0;
    r_resp   = 2'b00;
    r_last   = 1'b0;
    r_id     = '0;
    forever begin
      @(negedge clk);
      ar_hs    = ar_valid && ar_ready;
      r_hs     = r_valid && r_ready;
      ar_len_s = ar_len;
      @(posedge clk);
      #1;
      if (rst) begin
        ar_ready      = 1'b0;
        r_valid       = 1'b0;
        r_last        = 1'b0;
        r_resp        = 2'b00;
        beat_in_burst = 0;
        ar_wait       = 0;
        burst_q.delete();
      end else begin
        if (ar_hs) begin
          burst_q.push_back(ar_len_s);
          ar_ready = 1'b0;
          ar_wait  = 0;
        end else if (ar_valid) begin
          if (ar_wait >= cfg_ar_stall) ar_ready = 1'b1;
          else ar_wait++;
        end else begin
          ar_ready = 1'b0;
        end
        if (r_hs) begin
          r_valid = 1'b0;
          r_last  = 1'b0;
          beat_in_burst++;
          slave_beat++;
          if (beat_in_burst > int'(burst_q[0])) begin
            void'(burst_q.pop_front());
            beat_in_burst = 0;
          end
        end
        if (!r_valid && burst_q.size() > 0 && $urandom_range(0, 99) >= cfg_gap_pct) begin
          r_valid = 1'b1;
          r_data  = {cfg_tag, 16'(slave_beat)};
          r_resp  = (slave_beat == cfg_err_beat) ? 2'b10 : 2'b00;
          r_last  = (beat_in_burst == int'(burst_q[0])) || (slave_beat == cfg_early_last);
        end
      end
    end
  end

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!rst) begin
      if (ar_valid) begin
        arv_cycles++;
        if (prev_stall) begin
          check("ar_addr_stable", ar_addr, prev_addr);
          check("ar_len_stable", ar_len, prev_len);
        end
      end
      prev_stall = ar_valid && !ar_ready;
      prev_addr  = ar_addr;
      prev_len   = ar_len;
      if (ar_valid && ar_ready) begin
        check("ar_expected", exp_arq.size() != 0, 1);
        if (exp_arq.size() != 0) begin
          ar_t e;
          e = exp_arq.pop_front();
          check("ar_addr", ar_addr, e.addr);
          check("ar_len", ar_len, e.len);
        end
      end
      if (wr_en) begin
        wr_cnt++;
        check("wr_expected", exp_wq.size() != 0, 1);
        if (exp_wq.size() != 0) begin
          wr_t w;
          w = exp_wq.pop_front();
          check("wr_addr", wr_addr, w.addr);
          check("wr_data", wr_data, w.data);
        end
      end
      if (dma_r_done) begin
        done_cnt++;
        check("done_err", dma_r_err, exp_err);
        check("done_busy", dma_r_busy, 0);
        check("done_with_last_wr", wr_en, exp_last_wr);
        check("done_wq_left", exp_wq.size(), 0);
        check("done_arq_left", exp_arq.size(), 0);
      end
    end
  end

  task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l);
    exp_arq.push_back('{addr: a, len: l});
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [LW-1:0] n,
                             input logic [MAW-1:0] b);
    @(posedge clk);
    #2;
    araddr         = a;
    rd_len         = n;
    mem_base_waddr = b;
    start_dma_r    = 1'b1;
    @(posedge clk);
    #2;
    start_dma_r = 1'b0;
  endtask

  task automatic run_dma(input logic [AW-1:0] a, input logic [LW-1:0] n,
                         input logic [MAW-1:0] b, input logic [15:0] tag, input logic err);
    slave_beat  = 0;
    cfg_tag     = tag;
    exp_err     = err;
    exp_last_wr = (n != 0);
    for (int i = 0; i < int'(n); i++)
      exp_wq.push_back('{addr: MAW'(int'(b) + i), data: {tag, 16'(i)}});
    pulse_start(a, n, b);
    check("busy_after_start", dma_r_busy, n != 0);
    check("err_cleared_on_start", dma_r_err, 0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(tag, done_cnt, d0 + 1);
    repeat (4) @(posedge clk);
    check("single_done_pulse", done_cnt, d0 + 1);
  endtask

  initial begin
    int c;
    int w0;
    int d0;
    int arv0;
    start_dma_r    = 1'b0;
    araddr         = '0;
    rd_len         = '0;
    mem_base_waddr = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", dma_r_busy, 0);
    check("rst_done", dma_r_done, 0);
    check("rst_err", dma_r_err, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_arvalid", ar_valid, 0);
    check("rst_rready", r_ready, 0);
    check("rst_arsize", ar_size, 3'd2);
    check("rst_arburst", ar_burst, 2'b01);
    check("rst_arid", arid, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // 1: single aligned 16-beat burst, data = beat index
    push_ar(32'h1000, 8'd15);
    run_dma(32'h1000, 16'd16, 10'd0, 16'h0000, 1'b0);
    wait_done(400, "t1_done");

    // 2: 40 beats -> 16/16/8, plus a start pulse that must be ignored mid-transfer
    push_ar(32'h1000, 8'd15);
    push_ar(32'h1040, 8'd15);
    push_ar(32'h1080, 8'd7);
    run_dma(32'h1000, 16'd40, 10'd0, 16'h0002, 1'b0);
    repeat (8) @(posedge clk);
    check("t2_busy_mid", dma_r_busy, 1);
    pulse_start(32'h3000, 16'd5, 10'd500);
    wait_done(400, "t2_done");

    // 3: 4 KB boundary split
    push_ar(32'h0FF8, 8'd1);
    push_ar(32'h1000, 8'd5);
    run_dma(32'h0FF8, 16'd8, 10'd100, 16'h0003, 1'b0);
    wait_done(400, "t3_done");

    // 4: zero-length transfer
    arv0 = arv_cycles;
    run_dma(32'h0040, 16'd0, 10'd0, 16'h0004, 1'b0);
    wait_done(2, "t4_done_fast");
    check("t4_no_arvalid", arv_cycles, arv0);

    // 5: SLVERR on beat 3 and early RLAST on beat 5, then err clears on next start
    cfg_err_beat   = 3;
    cfg_early_last = 5;
    push_ar(32'h4000, 8'd15);
    run_dma(32'h4000, 16'd16, 10'd200, 16'h0005, 1'b1);
    wait_done(400, "t5_done");
    check("t5_err_sticky", dma_r_err, 1);
    cfg_err_beat   = -1;
    cfg_early_last = -1;
    push_ar(32'h5000, 8'd3);
    run_dma(32'h5000, 16'd4, 10'd300, 16'h0007, 1'b0);
    wait_done(400, "t5b_done");

    // 6: AR stall, RVALID gaps, memory pointer wrap, then reset mid-burst
    cfg_ar_stall = 5;
    cfg_gap_pct  = 40;
    cfg_err_beat = 2;
    push_ar(32'h2000, 8'd15);
    push_ar(32'h2040, 8'd15);
    w0 = wr_cnt;
    run_dma(32'h2000, 16'd32, 10'd1020, 16'h0006, 1'b1);
    c = 0;
    while (wr_cnt < w0 + 10 && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("t6_progress", wr_cnt >= w0 + 10, 1);
    check("t6_err_before_reset", dma_r_err, 1);
    d0 = done_cnt;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", dma_r_busy, 0);
    check("t6_rst_err", dma_r_err, 0);
    check("t6_rst_arvalid", ar_valid, 0);
    check("t6_rst_rready", r_ready, 0);
    exp_arq.delete();
    exp_wq.delete();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    check("t6_no_done", done_cnt, d0);
    check("t6_idle_busy", dma_r_busy, 0);

    // Recovery after the aborted transfer
    cfg_ar_stall = 0;
    cfg_gap_pct  = 0;
    cfg_err_beat = -1;
    push_ar(32'h0100, 8'd3);
    run_dma(32'h0100, 16'd4, 10'd10, 16'h0008, 1'b0);
    wait_done(400, "t7_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
